// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe 640x480@60 with a 25 MHz pixel rate from a 100 MHz clock.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Full period of one axis, visible part plus porches and sync.
  function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // Minimum bit width able to hold the value v (at least one bit).
  function automatic int bits_for(input int v);
    return (v <= 1) ? 1 : $clog2(v + 1);
  endfunction

  // True when a counter of width w can reach total-1.
  function automatic bit axis_fits(input int total, input int w);
    return bits_for(total - 1) <= w;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 on each advance, wraps, and registers the
// visible/sync decode of the value it is about to hold so decode and count
// change on the same edge.
module vga_axis_counter #(
  parameter int   W          = 10,
  parameter int   TOTAL      = 800,
  parameter int   ACTIVE     = 640,
  parameter int   SYNC_START = 656,
  parameter int   SYNC_END   = 752,
  parameter logic POL        = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         adv,
  output logic [W-1:0] cnt,
  output logic         act,
  output logic         sync,
  output logic         wrap
);

  localparam logic [W-1:0] LAST  = W'(TOTAL - 1);
  localparam logic [W:0]   ACT_L = (W + 1)'(ACTIVE);
  localparam logic [W:0]   SS_L  = (W + 1)'(SYNC_START);
  localparam logic [W:0]   SE_L  = (W + 1)'(SYNC_END);

  logic [W-1:0] nxt;
  logic [W:0]   nxt_x;

  // Next count and wrap indication; wrap is only meaningful while advancing.
  always_comb begin
    wrap = adv && (cnt == LAST);
    nxt  = cnt;
    if (adv) nxt = (cnt == LAST) ? '0 : cnt + W'(1);
    nxt_x = {1'b0, nxt};
  end

  // Count register plus decodes taken from the value being loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= LAST;
      act  <= 1'b0;
      sync <= ~POL;
    end else begin
      cnt  <= nxt;
      act  <= (nxt_x < ACT_L);
      sync <= (nxt_x >= SS_L && nxt_x < SE_L) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel strobe from the system clock,
// horizontal/vertical counters, sync, blanking, coordinates and line/frame pulses.
// Optional frame counter output when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV   = DEF_CLK_DIV,
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   XW        = 10,
  parameter int   YW        = 10
`ifdef VGA_TIMING_FRAME_CNT_EN
  , parameter int FCNT_W    = 16
`endif
) (
  input  logic          clk,
  input  logic          reset,
  output logic          pix_tick,
  output logic          hSync,
  output logic          vSync,
  output logic          active,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  , output logic [FCNT_W-1:0] frame_cnt
`endif
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = bits_for(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic             h_act, v_act, h_wrap, v_wrap;

  // Divider wraps at CLK_DIV-1; with CLK_DIV=1 it stays at zero.
  always_comb begin
    div_nxt = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
  end

  // pix_tick is registered so it is high exactly while div sits at CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      div      <= '0;
      pix_tick <= 1'b0;
    end else begin
      div      <= div_nxt;
      pix_tick <= (div_nxt == DIV_LAST);
    end
  end

  vga_axis_counter #(
    .W(XW), .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
    .SYNC_START(H_ACTIVE + H_FP), .SYNC_END(H_ACTIVE + H_FP + H_SYNC), .POL(HSYNC_POL)
  ) u_h (
    .clk(clk), .reset(reset), .adv(pix_tick),
    .cnt(x), .act(h_act), .sync(hSync), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .W(YW), .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
    .SYNC_START(V_ACTIVE + V_FP), .SYNC_END(V_ACTIVE + V_FP + V_SYNC), .POL(VSYNC_POL)
  ) u_v (
    .clk(clk), .reset(reset), .adv(h_wrap),
    .cnt(y), .act(v_act), .sync(vSync), .wrap(v_wrap)
  );

  // Both terms are flops loaded on the same edge, so active tracks x/y with no skew.
  assign active = h_act & v_act;

  // Line/frame pulses: a wrap only exists during the single pix_tick clock,
  // so each pulse covers just the first clock of the new pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Counts frames started; steps on the same edge that raises frame_start.
  always_ff @(posedge clk) begin
    if (reset) frame_cnt <= '0;
    else if (v_wrap) frame_cnt <= frame_cnt + FCNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen in a small raster:
// CLK_DIV=2, H 8/2/3/3 (16 total), V 4/1/2/1 (8 total), active-low syncs.
module tb_vga_timing_gen;

  localparam int XW = 4;
  localparam int YW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_tick, hSync, vSync, active, line_start, frame_start;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [1:0]    frame_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int n;

  logic [12:0] obs;
  assign obs = {pix_tick, hSync, vSync, active, line_start, frame_start, x, y};

  vga_timing_gen #(
    .CLK_DIV(2),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .XW(XW), .YW(YW)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .FCNT_W(2)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .pix_tick(pix_tick), .hSync(hSync), .vSync(vSync), .active(active),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  // clock/reset block
  always #5 clk = ~clk;

  // Advance one clock and sample 1ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Closed-form expectation for clock cyc after reset release (clk 3 = pixel (0,0)).
  function automatic logic [12:0] exp_at(input int cyc);
    int   k, p, xx, yy;
    logic pt, hs, vs, act, ls, fs;
    k   = cyc - 3;
    p   = k / 2;
    xx  = p % 16;
    yy  = (p / 16) % 8;
    pt  = (k % 2) == 1;
    hs  = !(xx >= 10 && xx < 13);
    vs  = !(yy >= 5 && yy < 7);
    act = (xx < 8) && (yy < 4);
    ls  = (k % 32) == 0;
    fs  = (k % 256) == 0;
    return {pt, hs, vs, act, ls, fs, 4'(xx), 3'(yy)};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) tick();
    checks++; if (x !== 4'd15) begin errors++; $display("FAIL reset_x got %0d want 15", x); end
    checks++; if (y !== 3'd7) begin errors++; $display("FAIL reset_y got %0d want 7", y); end
    checks++; if (hSync !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b want 1", hSync); end
    checks++; if (vSync !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b want 1", vSync); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", active); end
    checks++; if (pix_tick !== 1'b0) begin errors++; $display("FAIL reset_pix_tick got %b want 0", pix_tick); end
    checks++; if ({line_start, frame_start} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", {line_start, frame_start}); end
`ifdef VGA_TIMING_FRAME_CNT_EN
    checks++; if (frame_cnt !== 2'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
`endif
  endtask

  // Release reset and follow clocks 1..4.
  task automatic test_release();
    reset = 1'b0;
    checks++; if (pix_tick !== 1'b0) begin errors++; $display("FAIL rel_clk1_tick got %b want 0", pix_tick); end
    tick();
    checks++; if (pix_tick !== 1'b1 || x !== 4'd15) begin errors++; $display("FAIL rel_clk2 got tick=%b x=%0d want tick=1 x=15", pix_tick, x); end
    tick();
    checks++; if (obs !== 13'b0_1_1_1_1_1_0000_000) begin errors++; $display("FAIL rel_clk3 got %b want %b", obs, 13'b0_1_1_1_1_1_0000_000); end
`ifdef VGA_TIMING_FRAME_CNT_EN
    checks++; if (frame_cnt !== 2'd1) begin errors++; $display("FAIL rel_frame_cnt got %0d want 1", frame_cnt); end
`endif
    tick();
    checks++; if (obs !== 13'b1_1_1_1_0_0_0000_000) begin errors++; $display("FAIL rel_clk4 got %b want %b", obs, 13'b1_1_1_1_0_0_0000_000); end
`ifdef VGA_TIMING_FRAME_CNT_EN
    checks++; if (frame_cnt !== 2'd1) begin errors++; $display("FAIL rel_frame_cnt_hold got %0d want 1", frame_cnt); end
`endif
    n = 4;
  endtask

  // Free run for about three frames with per-clock comparison and one-frame tallies.
  task automatic test_free_run();
    int n_tick = 0, n_ls = 0, n_fs = 0, n_hlo = 0, n_vlo = 0, n_act = 0;
    int last_ls = 3, last_fs = 3;
    logic [12:0] e;
    for (int c = 5; c <= 770; c++) begin
      tick();
      n = c;
      e = exp_at(c);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL run_clk%0d got %b want %b", c, obs, e); end
      if (line_start === 1'b1) begin
        checks++;
        if (c - last_ls != 32) begin errors++; $display("FAIL line_period got %0d want 32", c - last_ls); end
        last_ls = c;
      end
      if (frame_start === 1'b1) begin
        checks++;
        if (c - last_fs != 256) begin errors++; $display("FAIL frame_period got %0d want 256", c - last_fs); end
        last_fs = c;
      end
      if (c >= 259 && c < 515) begin
        n_tick += int'(pix_tick === 1'b1);
        n_ls   += int'(line_start === 1'b1);
        n_fs   += int'(frame_start === 1'b1);
        n_hlo  += int'(hSync === 1'b0);
        n_vlo  += int'(vSync === 1'b0);
        n_act  += int'(active === 1'b1);
      end
    end
    checks++; if (n_tick != 128) begin errors++; $display("FAIL frame_ticks got %0d want 128", n_tick); end
    checks++; if (n_ls != 8) begin errors++; $display("FAIL frame_lines got %0d want 8", n_ls); end
    checks++; if (n_fs != 1) begin errors++; $display("FAIL frame_starts got %0d want 1", n_fs); end
    checks++; if (n_hlo != 48) begin errors++; $display("FAIL hsync_low_clks got %0d want 48", n_hlo); end
    checks++; if (n_vlo != 64) begin errors++; $display("FAIL vsync_low_clks got %0d want 64", n_vlo); end
    checks++; if (n_act != 64) begin errors++; $display("FAIL active_clks got %0d want 64", n_act); end
  endtask

  // One-clock reset at pixel (5,2), then restart from the frame origin.
  task automatic test_mid_reset();
    while (n < 845) begin
      tick();
      n++;
    end
    checks++; if (x !== 4'd5 || y !== 3'd2) begin errors++; $display("FAIL mid_pos got x=%0d y=%0d want x=5 y=2", x, y); end
    reset = 1'b1;
    tick();
    checks++; if (obs !== 13'b0_1_1_0_0_0_1111_111) begin errors++; $display("FAIL mid_reset_vals got %b want %b", obs, 13'b0_1_1_0_0_0_1111_111); end
`ifdef VGA_TIMING_FRAME_CNT_EN
    checks++; if (frame_cnt !== 2'd0) begin errors++; $display("FAIL mid_frame_cnt got %0d want 0", frame_cnt); end
`endif
    reset = 1'b0;
    tick();
    checks++; if (pix_tick !== 1'b1 || frame_start !== 1'b0) begin errors++; $display("FAIL mid_clk2 got tick=%b fs=%b want tick=1 fs=0", pix_tick, frame_start); end
    tick();
    checks++; if (obs !== 13'b0_1_1_1_1_1_0000_000) begin errors++; $display("FAIL mid_clk3 got %b want %b", obs, 13'b0_1_1_1_1_1_0000_000); end
`ifdef VGA_TIMING_FRAME_CNT_EN
    checks++; if (frame_cnt !== 2'd1) begin errors++; $display("FAIL mid_frame_cnt1 got %0d want 1", frame_cnt); end
`endif
    n = 3;
  endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Frame counter steps 1,2,3,0 across successive frame starts.
  task automatic test_frame_cnt();
    logic [1:0] want;
    want = 2'd1;
    for (int f = 0; f < 3; f++) begin
      repeat (256) tick();
      want = want + 2'd1;
      checks++; if (frame_start !== 1'b1 || frame_cnt !== want) begin errors++; $display("FAIL frame_cnt_%0d got fs=%b cnt=%0d want fs=1 cnt=%0d", f, frame_start, frame_cnt, want); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_release();
    test_free_run();
    test_mid_reset();
`ifdef VGA_TIMING_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
